// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the register-file writeback path.
//   DW       : data width of each architectural register
//   NREGS    : number of architectural registers
//   AW       : register address width
//   ZERO_REG : index of the hardwired-zero register ($zero)
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned DW       = 32;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned AW       = $clog2(NREGS);
    localparam int unsigned ZERO_REG = 0;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. Scans req starting at ptr,
//   wrapping modulo NREQ, and grants the first asserted request.
//   Ports:
//     req     in  NREQ  request vector (already masked by the caller)
//     ptr     in  2     index with highest priority this cycle (< NREQ)
//     gnt     out NREQ  one-hot grant, all-zero when req is all-zero
//     gnt_idx out 2     index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_idx
);

    logic            found;
    logic [1:0]      idx;
    logic [NREQ-1:0] shifted;

    // Shifts are used instead of variable bit-selects so the index width
    // need not match $clog2(NREQ) for every legal NREQ.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        shifted = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx     = 2'((32'(ptr) + k) % NREQ);
            shifted = req >> idx;
            if (!found && shifted[0]) begin
                found   = 1'b1;
                gnt     = NREQ'(1) << idx;
                gnt_idx = idx;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port among NREQ writeback
//   requesters. At most one write is granted per cycle, round-robin; the
//   winner's address is decoded into one-hot per-register write enables.
//   Ports:
//     clk          in   1        clock, rising edge
//     rst          in   1        asynchronous reset, active-low
//     rf_hold      in   1        register file frozen, no new grant
//     req_valid    in   NREQ     requester i has a pending write
//     req_addr     in   NREQ*AW  destination of requester i at [i*AW +: AW]
//     req_data     in   NREQ*DW  write data of requester i at [i*DW +: DW]
//     req_ready    out  NREQ     one-hot (or zero) grant, same cycle
//     rf_enable    out  NREGS    one-hot register write enables (registered)
//     rf_data      out  DW       broadcast write data (registered)
//     rf_wr        out  1        a write is performed this cycle (registered)
//     grant_id     out  2        requester whose write is on rf_* (registered)
//     conflict_cnt out  CW       only with REGFILE_ARB_CONFLICT_CNT_EN
//   Optional feature macro: REGFILE_ARB_CONFLICT_CNT_EN -- saturating count
//   of non-hold cycles with two or more valid requests.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int unsigned DW    = regfile_pkg::DW,
    parameter  int unsigned NREQ  = 3,
    parameter  int unsigned NREGS = regfile_pkg::NREGS,
    parameter  int unsigned CW    = 16,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rf_hold,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREGS-1:0]  rf_enable,
    output logic [DW-1:0]     rf_data,
    output logic              rf_wr,
    output logic [1:0]        grant_id
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    ,
    output logic [CW-1:0]     conflict_cnt
`endif
);

    logic [1:0]      rr_ptr;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_idx;
    logic            any_gnt;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [NREGS-1:0] dec;
    logic [1:0]      rr_ptr_nxt;

    // Hold masks requests before arbitration, so rr_ptr cannot move either.
    assign arb_req = rf_hold ? '0 : req_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // $zero and out-of-range addresses are granted but produce no enable.
    always_comb begin
        dec = '0;
        if ((32'(sel_addr) != ZERO_REG) && (32'(sel_addr) < NREGS)) begin
            dec = NREGS'(1) << sel_addr;
        end
    end

    assign rr_ptr_nxt = (32'(gnt_idx) == NREQ - 1) ? 2'd0 : gnt_idx + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_enable <= '0;
            rf_data   <= '0;
            rf_wr     <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else if (any_gnt) begin
            rf_enable <= dec;
            rf_data   <= sel_data;
            rf_wr     <= 1'b1;
            grant_id  <= gnt_idx;
            rr_ptr    <= rr_ptr_nxt;
        end else begin
            rf_enable <= '0;
            rf_wr     <= 1'b0;
        end
    end

`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    int unsigned nvalid;

    always_comb begin
        nvalid = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            nvalid = nvalid + 32'(req_valid[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (!rf_hold && (nvalid >= 2) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule : regfile_wb_arbiter
